// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised integer register file.
package reg_file_pkg;

    // Default data width used across the core.
    localparam int unsigned RF_XLEN_DEFAULT = 32;

    // Controller state: sweeping the array to zero, or normal operation.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Address width for a file of n registers (at least one bit).
    function automatic int unsigned rf_aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write bus of the register file: NRD read ports, one write port, ready.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = rf_aw(NREGS);

    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][XLEN-1:0] rd;
    logic                     we;
    logic [AW-1:0]            wa;
    logic [XLEN-1:0]          wd;
    logic                     ready;

    // Core side: issues addresses and write data.
    modport master (output ra, we, wa, wd, input rd, ready);
    // Register file side.
    modport slave  (input ra, we, wa, wd, output rd, ready);

endinterface

// File: rtl/reg_file_clear_ctl.sv
// Post-reset clear sequencer: walks every register index once, then enters RUN.
module reg_file_clear_ctl
    import reg_file_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state, state_n;
    logic [AW-1:0] idx, idx_n;

    // State and sweep index registers; reset restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic and clear strobe; the last index written ends the sweep.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        clr_we  = 1'b0;
        case (state)
            RF_CLEAR: begin
                clr_we = !rst;
                idx_n  = idx + AW'(1);
                if (idx == AW'(NREGS - 1)) begin
                    state_n = RF_RUN;
                end
            end
            RF_RUN: begin
                state_n = RF_RUN;
            end
        endcase
    end

    assign ready    = (state == RF_RUN);
    assign clr_addr = idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with optional zero register and
// same-cycle write-to-read bypass; contents swept to zero after every reset.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            run;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            zero_drop;
    logic            wr_fire;

    reg_file_clear_ctl #(
        .NREGS (NREGS)
    ) u_clear_ctl (
        .clk      (clk),
        .rst      (rst),
        .ready    (run),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.ready = run;
    assign zero_drop = (ZERO_REG != 0) && (bus.wa == '0);
    assign wr_fire   = run && !rst && bus.we && !zero_drop;

    // Array update: clear sweep has priority; core writes only land in RUN.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_fire) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Combinational read ports: zero while clearing, then zero-reg, bypass, array.
    always_comb begin
        bus.rd = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (!run || ((ZERO_REG != 0) && (bus.ra[p] == '0))) begin
                bus.rd[p] = '0;
            end else if ((BYPASS != 0) && wr_fire && (bus.wa == bus.ra[p])) begin
                bus.rd[p] = bus.wd;
            end else begin
                bus.rd[p] = regs[bus.ra[p]];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and model-checked bench for reg_file_mp: default build, a
// no-bypass build driven in lockstep, and a wide/short/4-port build.
module tb_reg_file_mp;

    logic clk;
    logic rst_a;
    logic rst_c;

    int checks = 0;
    int errors = 0;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifb ();
    reg_file_mp_if #(.XLEN(64), .NREGS(16), .NRD(4)) ifc ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk (clk), .rst (rst_a), .bus (ifa)
    );
    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk (clk), .rst (rst_a), .bus (ifb)
    );
    reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk (clk), .rst (rst_c), .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv_ab(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1);
        ifa.we = we;  ifb.we = we;
        ifa.wa = wa;  ifb.wa = wa;
        ifa.wd = wd;  ifb.wd = wd;
        ifa.ra[0] = r0; ifb.ra[0] = r0;
        ifa.ra[1] = r1; ifb.ra[1] = r1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [63:0] model [16];
    logic [63:0] exp_c;
    logic [63:0] rwd;
    logic [3:0]  rwa;
    logic        rwe;

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd3,  32'h1,        5'd3,  5'd7, 32'h1, 32'h12345678, 32'h0, 32'h12345678};
        vecs[5] = '{1'b1, 5'd3,  32'h2,        5'd3,  5'd3, 32'h2, 32'h2, 32'h1, 32'h1};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3, 32'h2, 32'h2, 32'h2, 32'h2};
        vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd3, 32'hCAFEF00D, 32'h2, 32'h0, 32'h2};
        vecs[8] = '{1'b1, 5'd0,  32'h5A5A5A5A, 5'd31, 5'd0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};
        vecs[9] = '{1'b0, 5'd31, 32'h11111111, 5'd31, 5'd5, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};

        rst_a = 1'b1;
        rst_c = 1'b1;
        drv_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        ifc.we = 1'b0;
        ifc.wa = '0;
        ifc.wd = '0;
        ifc.ra = '0;

        // Reset sweep with write attempts and reads of x5 throughout.
        @(negedge clk);
        rst_a = 1'b1;
        drv_ab(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk("sweep_ready_a", 64'(ifa.ready), 64'(k == 33));
            chk("sweep_ready_b", 64'(ifb.ready), 64'(k == 33));
            if (k <= 32) begin
                chk("sweep_rd_a0", 64'(ifa.rd[0]), 64'h0);
                chk("sweep_rd_a1", 64'(ifa.rd[1]), 64'h0);
                chk("sweep_rd_b0", 64'(ifb.rd[0]), 64'h0);
            end
        end
        drv_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Table: write/read, zero register, bypass vs no bypass.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_ab(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            #1;
            chk($sformatf("vec%0d_a0", i), 64'(ifa.rd[0]), 64'(vecs[i].ea0));
            chk($sformatf("vec%0d_a1", i), 64'(ifa.rd[1]), 64'(vecs[i].ea1));
            chk($sformatf("vec%0d_b0", i), 64'(ifb.rd[0]), 64'(vecs[i].eb0));
            chk($sformatf("vec%0d_b1", i), 64'(ifb.rd[1]), 64'(vecs[i].eb1));
        end

        // Reset mid-sweep: preload x9, reset, abort sweep after 10 cycles.
        @(negedge clk);
        drv_ab(1'b1, 5'd9, 32'h00000099, 5'd9, 5'd9);
        @(negedge clk);
        drv_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        chk("pre_x9_a", 64'(ifa.rd[0]), 64'h99);
        chk("pre_x9_b", 64'(ifb.rd[1]), 64'h99);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("mid_ready_a", 64'(ifa.ready), 64'h0);
        end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk("resweep_ready_a", 64'(ifa.ready), 64'(k == 33));
            if (k <= 32) chk("resweep_rd_a0", 64'(ifa.rd[0]), 64'h0);
            if (k == 20) drv_ab(1'b1, 5'd9, 32'hBAD0BAD0, 5'd9, 5'd9);
            if (k == 21) drv_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        end
        chk("post_x9_a", 64'(ifa.rd[0]), 64'h0);
        chk("post_x9_b", 64'(ifb.rd[1]), 64'h0);

        // Wide build: 16-cycle sweep, writable x0 on four ports, random traffic.
        @(negedge clk);
        rst_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk("c_sweep_ready", 64'(ifc.ready), 64'(k == 17));
            if (k <= 16) chk("c_sweep_rd0", ifc.rd[0], 64'h0);
        end
        ifc.we = 1'b1;
        ifc.wa = 4'd0;
        ifc.wd = 64'hA5A5A5A5A5A5A5A5;
        ifc.ra = '0;
        @(negedge clk);
        ifc.we = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("c_x0_p%0d", p), ifc.rd[p], 64'hA5A5A5A5A5A5A5A5);
        end

        for (int i = 0; i < 16; i++) model[i] = 64'h0;
        model[0] = 64'hA5A5A5A5A5A5A5A5;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rwe = 1'($urandom_range(0, 1));
            rwa = 4'($urandom_range(0, 15));
            rwd = {$urandom, $urandom};
            ifc.we = rwe;
            ifc.wa = rwa;
            ifc.wd = rwd;
            for (int p = 0; p < 4; p++) begin
                ifc.ra[p] = ($urandom_range(0, 3) == 0) ? rwa : 4'($urandom_range(0, 15));
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                exp_c = (rwe && (rwa == ifc.ra[p])) ? rwd : model[ifc.ra[p]];
                chk($sformatf("c_rand%0d_p%0d", i, p), ifc.rd[p], exp_c);
            end
            if (rwe) model[rwa] = rwd;
        end
        @(negedge clk);
        ifc.we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the fixed 2R1W 32x32 file.
- Adds configurable XLEN, register count and read-port count.
- Adds an optional same-cycle write-to-read bypass.
- Adds a sequential post-reset clear sweep with a ready indication.
- Sits in the decode/writeback path of the core; read ports feed operand fetch, the write port is driven by writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of independent read ports, >= 1.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.
- BYPASS, 1, 1 = a read of the address being written this cycle returns the write data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- ra  in  NRD x AW  read addresses, one per port; AW = $clog2(NREGS).
- rd  out  NRD x XLEN  read data, combinational from ra.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- ready  out  1  high when the clear sweep has finished and writes are accepted.

Behaviour:
- States:
  - CLEAR: sweeping registers to zero.
  - RUN: normal operation.
- Reset:
  - rst high at an edge sets state to CLEAR and clear index to 0. The array is not cleared in that edge.
  - ready = 0 from the cycle after the reset edge.
  - rst held high keeps the block in CLEAR with the index at 0.
- CLEAR sweep:
  - Each edge with rst low writes 0 to regs[idx], then increments idx.
  - When idx = NREGS-1 is written, state goes to RUN and ready goes to 1 on the following cycle.
  - The sweep takes exactly NREGS cycles after rst is released.
- Before the first reset, state and idx are don't-care. The bench must apply rst before checking anything.
- Writes in CLEAR: we is ignored and the array is not modified by wa/wd.
- Reads in CLEAR: every rd port returns 0, regardless of ra or bypass.
- RUN writes: on an edge with we = 1, regs[wa] <= wd. If ZERO_REG = 1 and wa = 0, the write is dropped.
- RUN reads: each port p is combinational, zero added latency:
  - If ZERO_REG and ra[p] = 0, rd[p] = 0.
  - Else if BYPASS and we and wa = ra[p] and the write is not dropped, rd[p] = wd.
  - Else rd[p] = regs[ra[p]].
- BYPASS = 0: a read of the address being written returns the old value; the new value is visible from the next cycle.
- Multiple read ports with the same address return identical data, bypass included.
- Reset mid-sweep: the sweep restarts at index 0, ready stays 0, and a full NREGS-cycle sweep follows.
- Reset in RUN: ready falls, then a full sweep runs. Contents after the sweep are all zero.
- A write on the same edge that rst is asserted is discarded.
- Width rules:
  - No arithmetic on data.
  - idx is AW bits wide. It does not wrap in a way that can be observed, because the transition to RUN happens when idx = NREGS-1.

Decomposition:
- Package reg_file_pkg holds:
  - the state enum rf_state_e {RF_CLEAR, RF_RUN};
  - a helper function for AW ($clog2 wrapper);
  - a localparam for the default XLEN shared with the rest of the core.
- The array, write logic and NRD-way read generate loop stay in reg_file_mp.
- One natural sub-module, reg_file_clear_ctl, owns:
  - the state register and idx counter;
  - ready;
  - the internal clear-write strobe/address.
- reg_file_clear_ctl is parametrised by NREGS.

Test Plan:
1. Reset sweep: rst 1 cycle, then low. ready = 0 for exactly 32 cycles and 1 on cycle 33. All ports read 0 during the sweep; ra = 5 reads 0 even with we = 1, wa = 5, wd = 0xDEADBEEF.
2. Write/read: in RUN, write x7 = 0x12345678. The next cycle, port0 ra = 7 reads 0x12345678 and port1 ra = 7 reads the same.
3. Zero register: write wa = 0, wd = 0xFFFFFFFF. ra = 0 reads 0 in the same cycle and the next, on both ports.
4. Bypass:
   - BYPASS = 1: x3 holds 0x1, write x3 = 0x2, ra = 3 in the same cycle reads 0x2.
   - Rebuild with BYPASS = 0: the same stimulus reads 0x1, then 0x2 the next cycle.
5. Reset mid-sweep: release rst, reassert after 10 cycles, release. ready stays 0 for 32 further cycles. A write attempted at cycle 20 of the new sweep is not visible after ready.
6. Parameter sweep: XLEN = 64, NREGS = 16, NRD = 4, ZERO_REG = 0.
   - The sweep takes 16 cycles.
   - Write x0 = 0xA5A5A5A5A5A5A5A5; all four ports with ra = 0 read it the next cycle.
   - Random traffic is checked against a reference model.
